conv_window_sequencer: RTL and testbench
========================================

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3: square kernel side K (K >= 2).
REQ-002 SHALL have parameter IMAGE_SIZE, default 8: square image side N (N > K).
REQ-003 SHALL have parameter ADDR_WIDTH, default 6: image ROM address width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  run/freeze qualifier.
REQ-007 SHALL have port start  input  1  start a frame; sampled only in IDLE.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first ROM address of the frame, latched on start.
REQ-009 SHALL have port rom_rd_en  output  1  ROM read strobe.
REQ-010 SHALL have port rom_addr  output  ADDR_WIDTH  ROM read address.
REQ-011 SHALL have port input_interface_cmd  output  2  0 NOP, 1 LOAD.
REQ-012 SHALL have port kernel_array_cmd  output  2  0 NOP, 1 SHIFT, 2 BIAS, 3 CLEAR.
REQ-013 SHALL have port output_interface_cmd  output  1  1 = write one output row.
REQ-014 SHALL have ports shift_idx and row_idx  output  clog2(K) each  current kernel column and row.
REQ-015 SHALL have ports busy and done  output  1 each  busy = not IDLE; done = one-cycle frame-complete pulse.

Function
REQ-016 SHALL implement states IDLE, PRELOAD, SHIFT, BIAS, LOAD_ROW, DONE; all outputs decode combinationally from registered state and counters.
REQ-017 SHALL move IDLE->PRELOAD when start=1 and enable=1, latching base_addr; in that IDLE cycle kernel_array_cmd=CLEAR, otherwise NOP in IDLE.
REQ-018 SHALL, in PRELOAD, drive rom_rd_en=1, input_interface_cmd=LOAD, rom_addr=base+n for n = 0..K*N-1, then go to SHIFT.
REQ-019 SHALL, in SHIFT, last K*K cycles with kernel_array_cmd=SHIFT, shift_idx stepping 0..K-1 fastest and row_idx 0..K-1, then go to BIAS.
REQ-020 SHALL, in BIAS, last 1 cycle with kernel_array_cmd=BIAS and output_interface_cmd=1, then go to LOAD_ROW if the output row count < N-K, else DONE.
REQ-021 SHALL, in LOAD_ROW, last N cycles with rom_rd_en=1 and LOAD, addresses continuing sequentially from the last issued address, then return to SHIFT.
REQ-022 SHALL produce exactly N-K+1 BIAS cycles and N*N reads per frame; the last address is base+N*N-1.
REQ-023 SHALL, in DONE, assert done for 1 cycle and return to IDLE.
REQ-024 SHALL compute rom_addr modulo 2^ADDR_WIDTH; wrap-around past the maximum address is legal and silent.
REQ-025 SHALL, when enable=0, freeze state and all counters, and force rom_rd_en=0, all cmds=NOP and done=0 while keeping busy valid.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL keep shift_idx and row_idx at 0 outside SHIFT.

Reset
REQ-028 SHALL, on rst_n=0 (any state, mid-frame included), immediately enter IDLE with counters 0, rom_addr=0, rom_rd_en=0, cmds=NOP, busy=0 and done=0.
REQ-029 SHALL resume only on a new start after reset release; no partial frame completes.

Configuration
REQ-030 SHALL, with CONV_SEQ_ABORT_EN defined, add input abort (1 bit); abort=1 in any non-IDLE state forces IDLE on the next edge, with no done and cmds=NOP that cycle, and abort has priority over enable.
REQ-031 SHALL, without CONV_SEQ_ABORT_EN, have no abort port and behave per REQ-016..027.

Verification
REQ-032 SHALL verify: defaults, base_addr=0, start pulse, enable=1 -> 24 PRELOAD reads at addresses 0..23, 6 BIAS pulses, 64 reads total ending at address 63, and done exactly 125 cycles after the start edge.
REQ-033 SHALL verify: base_addr=50, ADDR_WIDTH=6 -> addresses run 50..63 then 0..49, with no error.
REQ-034 SHALL verify: enable=0 for 5 cycles mid-LOAD_ROW -> rom_rd_en=0 and cmds=NOP during the stall, the address sequence resumes unbroken, and done arrives 5 cycles later.
REQ-035 SHALL verify: start pulsed during SHIFT -> ignored, and the frame timing is unchanged.
REQ-036 SHALL verify: rst_n low at cycle 40 -> all outputs 0 that cycle, and after release the block stays IDLE until start.
REQ-037 SHALL verify: with CONV_SEQ_ABORT_EN, abort in BIAS -> IDLE next cycle with done never asserted; K=5, N=12 -> 8 BIAS pulses with 25 SHIFT cycles each.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// Control sequencer for a KxK convolution window sliding down an NxN image held in ROM.
// Optional abort input is compiled in when CONV_SEQ_ABORT_EN is defined.
module conv_window_sequencer #(
   parameter int KERNEL_SIZE = 3,
   parameter int IMAGE_SIZE  = 8,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
`ifdef CONV_SEQ_ABORT_EN
   input  logic                          abort,
`endif
   output logic                          rom_rd_en,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   output logic [1:0]                    input_interface_cmd,
   output logic [1:0]                    kernel_array_cmd,
   output logic                          output_interface_cmd,
   output logic [$clog2(KERNEL_SIZE)-1:0] shift_idx,
   output logic [$clog2(KERNEL_SIZE)-1:0] row_idx,
   output logic                          busy,
   output logic                          done
);

   localparam int K   = KERNEL_SIZE;
   localparam int N   = IMAGE_SIZE;
   localparam int KW  = $clog2(K);
   localparam int CW  = $clog2(K * N);
   localparam int ORW = $clog2(N - K + 1);

   localparam logic [CW-1:0]  PRE_LAST  = CW'(K * N - 1);
   localparam logic [CW-1:0]  ROW_LAST  = CW'(N - 1);
   localparam logic [KW-1:0]  K_LAST    = KW'(K - 1);
   localparam logic [ORW-1:0] OROW_LAST = ORW'(N - K);

   localparam logic [1:0] II_NOP = 2'd0, II_LOAD = 2'd1;
   localparam logic [1:0] KA_NOP = 2'd0, KA_SHIFT = 2'd1, KA_BIAS = 2'd2, KA_CLEAR = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_PRELOAD, S_SHIFT, S_BIAS, S_LOAD_ROW, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [KW-1:0]         col_q, col_d;
   logic [KW-1:0]         krow_q, krow_d;
   logic [ORW-1:0]        orow_q, orow_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  abort_w;

`ifdef CONV_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         col_q   <= '0;
         krow_q  <= '0;
         orow_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         krow_q  <= krow_d;
         orow_q  <= orow_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      cnt_d                = cnt_q;
      col_d                = col_q;
      krow_d               = krow_q;
      orow_d               = orow_q;
      addr_d               = addr_q;
      rom_rd_en            = 1'b0;
      input_interface_cmd  = II_NOP;
      kernel_array_cmd     = KA_NOP;
      output_interface_cmd = 1'b0;
      done                 = 1'b0;
      busy                 = (state_q != S_IDLE);
      rom_addr             = addr_q;
      shift_idx            = (state_q == S_SHIFT) ? col_q  : '0;
      row_idx              = (state_q == S_SHIFT) ? krow_q : '0;

      // Abort outranks enable and emits nothing on its way back to idle
      if (abort_w && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         col_d   = '0;
         krow_d  = '0;
         orow_d  = '0;
      end else if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  kernel_array_cmd = KA_CLEAR;
                  state_d          = S_PRELOAD;
                  addr_d           = base_addr;
                  cnt_d            = '0;
                  orow_d           = '0;
               end
            end
            S_PRELOAD: begin
               rom_rd_en           = 1'b1;
               input_interface_cmd = II_LOAD;
               addr_d              = addr_q + ADDR_WIDTH'(1);
               if (cnt_q == PRE_LAST) begin
                  cnt_d   = '0;
                  state_d = S_SHIFT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_SHIFT: begin
               kernel_array_cmd = KA_SHIFT;
               if (col_q == K_LAST) begin
                  col_d = '0;
                  if (krow_q == K_LAST) begin
                     krow_d  = '0;
                     state_d = S_BIAS;
                  end else begin
                     krow_d = krow_q + KW'(1);
                  end
               end else begin
                  col_d = col_q + KW'(1);
               end
            end
            S_BIAS: begin
               kernel_array_cmd     = KA_BIAS;
               output_interface_cmd = 1'b1;
               if (orow_q == OROW_LAST) begin
                  orow_d  = '0;
                  state_d = S_DONE;
               end else begin
                  orow_d  = orow_q + ORW'(1);
                  state_d = S_LOAD_ROW;
               end
            end
            S_LOAD_ROW: begin
               rom_rd_en           = 1'b1;
               input_interface_cmd = II_LOAD;
               addr_d              = addr_q + ADDR_WIDTH'(1);
               if (cnt_q == ROW_LAST) begin
                  cnt_d   = '0;
                  state_d = S_SHIFT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: per-cycle comparison against a frame trace built from
// the sequencing rules, with frame-level totals; abort checks when CONV_SEQ_ABORT_EN is set.
module tb_conv_window_sequencer;

   typedef struct packed {
      logic       rd;
      logic [7:0] addr;
      logic [1:0] ii;
      logic [1:0] kc;
      logic       oc;
      logic [2:0] si;
      logic [2:0] ri;
      logic       dn;
      logic       by;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, enable, start_s;
   logic [7:0] base_s;
   int         sel;

   logic       a_rd, a_oc, a_busy, a_done;
   logic [5:0] a_addr;
   logic [1:0] a_ii, a_kc, a_si, a_ri;
   logic       b_rd, b_oc, b_busy, b_done;
   logic [7:0] b_addr;
   logic [1:0] b_ii, b_kc;
   logic [2:0] b_si, b_ri;
`ifdef CONV_SEQ_ABORT_EN
   logic       abort_s;
`endif

   conv_window_sequencer #(.KERNEL_SIZE(3), .IMAGE_SIZE(8), .ADDR_WIDTH(6)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_s && sel == 0),
      .base_addr(base_s[5:0]),
`ifdef CONV_SEQ_ABORT_EN
      .abort(abort_s && sel == 0),
`endif
      .rom_rd_en(a_rd), .rom_addr(a_addr), .input_interface_cmd(a_ii),
      .kernel_array_cmd(a_kc), .output_interface_cmd(a_oc), .shift_idx(a_si),
      .row_idx(a_ri), .busy(a_busy), .done(a_done));

   conv_window_sequencer #(.KERNEL_SIZE(5), .IMAGE_SIZE(12), .ADDR_WIDTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .start(start_s && sel == 1),
      .base_addr(base_s),
`ifdef CONV_SEQ_ABORT_EN
      .abort(abort_s && sel == 1),
`endif
      .rom_rd_en(b_rd), .rom_addr(b_addr), .input_interface_cmd(b_ii),
      .kernel_array_cmd(b_kc), .output_interface_cmd(b_oc), .shift_idx(b_si),
      .row_idx(b_ri), .busy(b_busy), .done(b_done));

   ent_t obs;
   always_comb begin
      obs = '0;
      if (sel == 0) begin
         obs.rd = a_rd; obs.addr = {2'b00, a_addr}; obs.ii = a_ii; obs.kc = a_kc;
         obs.oc = a_oc; obs.si = {1'b0, a_si}; obs.ri = {1'b0, a_ri};
         obs.dn = a_done; obs.by = a_busy;
      end else begin
         obs.rd = b_rd; obs.addr = b_addr; obs.ii = b_ii; obs.kc = b_kc;
         obs.oc = b_oc; obs.si = b_si; obs.ri = b_ri;
         obs.dn = b_done; obs.by = b_busy;
      end
   end

   ent_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   dcyc;

   task automatic chk_ent(input string tag, input int cyc, input ent_t o, input ent_t e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
      end
   endtask

   task automatic chk_int(input string tag, input int o, input int e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   function automatic ent_t mk(input int rd, input int addr, input int ii, input int kc,
                               input int oc, input int si, input int ri, input int dn,
                               input int by);
      ent_t e;
      e.rd = 1'(rd); e.addr = 8'(addr); e.ii = 2'(ii); e.kc = 2'(kc); e.oc = 1'(oc);
      e.si = 3'(si); e.ri = 3'(ri); e.dn = 1'(dn); e.by = 1'(by);
      return e;
   endfunction

   // Expected per-cycle trace of one uninterrupted frame, starting with the start cycle in idle
   task automatic build(input int k, input int n, input int base, input int aw);
      int a;
      a = base;
      exp_q.delete();
      exp_q.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0));
      for (int i = 0; i < k * n; i++) begin
         exp_q.push_back(mk(1, a % (1 << aw), 1, 0, 0, 0, 0, 0, 1));
         a++;
      end
      for (int r = 0; r <= n - k; r++) begin
         for (int row = 0; row < k; row++)
            for (int col = 0; col < k; col++)
               exp_q.push_back(mk(0, 0, 0, 1, 0, col, row, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 2, 1, 0, 0, 0, 1));
         if (r < n - k)
            for (int i = 0; i < n; i++) begin
               exp_q.push_back(mk(1, a % (1 << aw), 1, 0, 0, 0, 0, 0, 1));
               a++;
            end
      end
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
   endtask

   // Called at posedge+1; returns at posedge+1
   task automatic run_frame(input int s, input int k, input int n, input int aw,
                            input int base, input int stall_at, input int stall_len,
                            input int spur_at, input int rst_at, input int abort_at,
                            output int done_cyc);
      int idx, cyc, n_rd, n_bias, last_addr, shift_run;
      bit stalled, cut;
      ent_t e, o;
      idx = 0; cyc = 0; n_rd = 0; n_bias = 0; last_addr = -1; shift_run = 0;
      done_cyc = -1; cut = 0;
      sel = s;
      base_s = 8'(base);
      while (idx < exp_q.size()) begin
         stalled = (cyc >= stall_at) && (cyc < stall_at + stall_len);
         enable  = !stalled;
         start_s = (idx == 0 && !stalled) || (cyc == spur_at);
`ifdef CONV_SEQ_ABORT_EN
         abort_s = (cyc == abort_at);
`endif
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_ent("reset_mid_frame", cyc, obs, '0);
            cut = 1;
            break;
         end
         @(negedge clk);
         e = exp_q[idx];
         if (stalled || cyc == abort_at) begin
            e.rd = 0; e.addr = 0; e.ii = 0; e.kc = 0; e.oc = 0; e.dn = 0;
         end
         o = obs;
         if (!o.rd) o.addr = '0;
         chk_ent(stalled ? "stall_cycle" : "trace", cyc, o, e);
         if (o.rd) begin
            n_rd++;
            last_addr = int'(o.addr);
         end
         if (o.kc == 2'd1) shift_run++;
         if (o.kc == 2'd2) begin
            n_bias++;
            chk_int("shift_cycles_per_bias", shift_run, k * k);
            shift_run = 0;
         end
         if (o.dn) done_cyc = cyc;
         @(posedge clk);
         #1;
         if (cyc == abort_at) begin
            cut = 1;
            break;
         end
         if (!stalled) idx++;
         cyc++;
      end
      start_s = 1'b0;
      enable  = 1'b1;
`ifdef CONV_SEQ_ABORT_EN
      abort_s = 1'b0;
`endif
      if (!cut) begin
         chk_int("reads_per_frame", n_rd, n * n);
         chk_int("bias_per_frame", n_bias, n - k + 1);
         chk_int("last_address", last_addr, (base + n * n - 1) % (1 << aw));
         chk_int("done_cycle", done_cyc,
                 1 + k * n + (n - k + 1) * (k * k + 1) + (n - k) * n + stall_len);
         @(negedge clk);
         chk_int("idle_after_frame", {31'd0, obs.by} + {31'd0, obs.dn}, 0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_cycles(input string tag, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         chk_int(tag, {29'd0, obs.by, obs.dn, obs.rd}, 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; start_s = 1'b0; base_s = 8'd0; sel = 0;
`ifdef CONV_SEQ_ABORT_EN
      abort_s = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_ent("reset_state", -1, obs, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      enable = 1'b1;

      // default frame from address 0
      build(3, 8, 0, 6);
      run_frame(0, 3, 8, 6, 0, -1, 0, -1, -1, -1, dcyc);
      chk_int("done_latency_default", dcyc, 125);

      // wrapping address range
      build(3, 8, 50, 6);
      run_frame(0, 3, 8, 6, 50, -1, 0, -1, -1, -1, dcyc);

      // five-cycle stall inside the first row reload
      build(3, 8, 0, 6);
      run_frame(0, 3, 8, 6, 0, 38, 5, -1, -1, -1, dcyc);
      chk_int("done_latency_stall", dcyc, 130);

      // stray start while shifting
      build(3, 8, $urandom_range(63), 6);
      run_frame(0, 3, 8, 6, int'(exp_q[1].addr), -1, 0, 28, -1, -1, dcyc);
      chk_int("done_latency_spurious_start", dcyc, 125);

      // randomized stall position and length
      begin
         int sa, sl, bs;
         sa = 1 + $urandom_range(120);
         sl = 1 + $urandom_range(6);
         bs = $urandom_range(63);
         build(3, 8, bs, 6);
         run_frame(0, 3, 8, 6, bs, sa, sl, -1, -1, -1, dcyc);
      end

      // reset in the middle of a frame
      build(3, 8, 0, 6);
      run_frame(0, 3, 8, 6, 0, -1, 0, -1, 40, -1, dcyc);
      chk_int("reset_addr_zero", int'(a_addr), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycles("idle_after_reset", 10);
      build(3, 8, 7, 6);
      run_frame(0, 3, 8, 6, 7, -1, 0, -1, -1, -1, dcyc);

      // larger kernel and image
      begin
         int bs;
         bs = 150 + $urandom_range(100);
         build(5, 12, bs, 8);
         run_frame(1, 5, 12, 8, bs, -1, 0, -1, -1, -1, dcyc);
      end

`ifdef CONV_SEQ_ABORT_EN
      // abort during the first bias cycle
      build(3, 8, 0, 6);
      run_frame(0, 3, 8, 6, 0, -1, 0, -1, -1, 34, dcyc);
      idle_cycles("idle_after_abort", 20);
      build(3, 8, 3, 6);
      run_frame(0, 3, 8, 6, 3, -1, 0, -1, -1, -1, dcyc);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
